// File: rtl/serial_adder_if.sv
// Handshake and data bundle for serial_adder.
//   master: drives start/A/B/Cin, observes Sum/Carry/Ovf/busy/done
//   slave : the adder itself
interface serial_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic [WIDTH-1:0] Sum;
   logic             Carry;
   logic             Ovf;
   logic             busy;
   logic             done;

   modport master (
      output start, A, B, Cin,
      input  Sum, Carry, Ovf, busy, done
   );

   modport slave (
      input  start, A, B, Cin,
      output Sum, Carry, Ovf, busy, done
   );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: A + B + Cin computed DIGIT bits per clock through a
// registered carry, with start/busy/done handshake, unsigned carry-out and
// two's-complement overflow.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - serial_adder_if.slave: start, A, B, Cin in; Sum, Carry, Ovf,
//           busy, done out (all outputs registered)
module serial_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);

   localparam int unsigned N     = WIDTH / DIGIT;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DW    = DIGIT + 1;

   if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
      $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               c_q, c_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   psum_q, psum_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [DIGIT:0]     dsum_c;
   logic               msb_cin_c;
   logic [WIDTH-1:0]   psum_sh_c;

   // One digit of the ripple: low DIGIT bits of each operand plus running carry
   assign dsum_c = DW'(a_q[DIGIT-1:0]) + DW'(b_q[DIGIT-1:0]) + DW'(c_q);

   // Carry into the digit MSB recovered from sum = a ^ b ^ cin at that bit
   assign msb_cin_c = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum_c[DIGIT-1];

   // New digit enters at the top; after N shifts digit 0 sits at bit 0
   assign psum_sh_c = (psum_q >> DIGIT) | (WIDTH'(dsum_c[DIGIT-1:0]) << (WIDTH - DIGIT));

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         psum_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         psum_q  <= psum_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      psum_d  = psum_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE, DONE: begin
            // DONE accepts start directly so back-to-back ops have no bubble
            if (bus.start) begin
               a_d     = bus.A;
               b_d     = bus.B;
               c_d     = bus.Cin;
               cnt_d   = '0;
               psum_d  = '0;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            a_d    = a_q >> DIGIT;
            b_d    = b_q >> DIGIT;
            c_d    = dsum_c[DIGIT];
            psum_d = psum_sh_c;
            cnt_d  = CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_W'(N - 1)) begin
               sum_d   = psum_sh_c;
               carry_d = dsum_c[DIGIT];
               ovf_d   = msb_cin_c ^ dsum_c[DIGIT];
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == BUSY);
      done_d = (state_d == DONE);
   end

   assign bus.Sum   = sum_q;
   assign bus.Carry = carry_q;
   assign bus.Ovf   = ovf_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit half adder.
- Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, through a registered carry chain.
- Start/busy/done handshake; reports unsigned carry-out and signed overflow.
- Used where a full-width combinational adder would break timing or cost too much area.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits added per clock cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when the FSM is in IDLE or DONE.
- A  input  WIDTH  operand A; captured on the edge that accepts start.
- B  input  WIDTH  operand B; captured on the edge that accepts start.
- Cin  input  1  carry-in; captured on the edge that accepts start.
- Sum  output  WIDTH  registered result of A+B+Cin, modulo 2^WIDTH.
- Carry  output  1  unsigned carry-out of bit WIDTH-1.
- Ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high while digits are being processed.
- done  output  1  single-cycle pulse; result valid from this cycle onward.

Behaviour:
- Reset:
  - rst_n low forces FSM to IDLE immediately, independent of clk.
  - Sum=0, Carry=0, Ovf=0, busy=0, done=0.
  - Operand shift registers, carry register and digit counter all clear.
- Definitions: N = WIDTH/DIGIT. Counter width is clog2(N), minimum 1 bit.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - start=1 at edge k latches A, B, Cin; counter=0; go to BUSY.
  - busy is high from edge k.
- BUSY, each edge:
  - Add the low DIGIT bits of the A and B shift registers plus the carry register.
  - Shift the DIGIT-bit result into the MSB end of a partial-sum register.
  - Shift both operand registers right by DIGIT.
  - Carry register takes the digit carry-out; counter increments.
  - start is ignored while in BUSY.
- Final digit (counter==N-1), at edge k+N:
  - Sum, Carry and Ovf are loaded in one shot.
  - Ovf is taken from the MSB position of the final digit.
  - FSM goes to DONE; busy falls; done=1 for exactly one cycle.
- Latency: done is high in the cycle after edge k+N, i.e. N cycles after start is accepted. DIGIT=WIDTH gives 1 cycle.
- DONE:
  - Lasts one cycle.
  - start=1 in this cycle is accepted: new operands latched, back to BUSY, no idle bubble.
  - Otherwise go to IDLE.
- Output hold: Sum, Carry and Ovf hold the last result until the next final-digit edge. They are never changed by start alone.
- Operand stability: A, B and Cin may change freely after the accepting edge.
- Reset mid-operation: the operation is aborted; done never pulses for it; outputs return to 0.

Test Plan:
1. WIDTH=16, DIGIT=4; A=16'hFFFF, B=16'h0001, Cin=0, start for one cycle -> busy high 4 cycles, done pulses 4 cycles after start; Sum=16'h0000, Carry=1, Ovf=0.
2. A=16'h7FFF, B=16'h0001, Cin=0 -> Sum=16'h8000, Carry=0, Ovf=1. Then A=16'h1234, B=16'h4321, Cin=1 -> Sum=16'h5556, Carry=0, Ovf=0.
3. Back-to-back: start held high continuously, operand pairs (16'h0001,16'h0002) then (16'h8000,16'h8000) -> done pulses at cycles 4 and 9 (one DONE cycle between operations); Sum=16'h0003, then Sum=16'h0000 with Carry=1, Ovf=1.
4. During BUSY of 16'h0010+16'h0020, drive start=1 with A=16'hFFFF -> ignored; result is Sum=16'h0030; no extra done pulse.
5. rst_n low at cycle 2 of an operation -> all outputs 0 immediately, no done pulse; a fresh start after release completes normally.
6. WIDTH=8, DIGIT=8; A=8'hC8, B=8'h64, Cin=0 -> done 1 cycle after start; Sum=8'h2C, Carry=1, Ovf=0. Also WIDTH=8, DIGIT=1 -> latency 8 cycles, same result.
